wb_bypass_arbiter: RTL

- Single-port writeback arbiter for the out-of-order core: shares one result bus among the functional units (ALU, MEM, MUL, DIV, FPU).
- Registers the winning result onto the writeback bus, which feeds the PRF write, ROB done-marking and IQ wakeup.
- Keeps the last BYPASS_LENGTH writebacks as bypass entries (valid, phys_rd, result).
- Serves two combinational bypass lookup ports (rs1/rs2 of the issuing instruction).

---
 rtl/wb_bypass_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_bypass_arbiter.sv
// Writeback arbiter: round-robin selection of one functional-unit result per
// cycle onto a registered writeback bus. The last BYPASS_LENGTH writebacks are
// kept as bypass entries, and two combinational lookup ports read them.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             pipeline flush; suppresses the grant, clears wb/bypass valid
//   fu_valid/fu_ready per-FU request/grant handshake (FU 0=ALU .. 4=FPU)
//   fu_rd_we, fu_phys_rd, fu_result, fu_rob_idx   per-FU result payload, FU i at slice i
//   wb_*              registered writeback bus (PRF write, ROB done, IQ wakeup)
//   byp_*             bypass history, entry 0 youngest
//   q_tag/q_hit/q_data  two lookup ports (0 = rs1, 1 = rs2)
module wb_bypass_arbiter #(
  parameter int unsigned NUM_FU         = 5,
  parameter int unsigned INT_DATA_W     = 32,
  parameter int unsigned PHYS_REG_IDX_W = 6,
  parameter int unsigned ROB_IDX_W      = 4,
  parameter int unsigned BYPASS_LENGTH  = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_FU-1:0]                       fu_valid,
  output logic [NUM_FU-1:0]                       fu_ready,
  input  logic [NUM_FU-1:0]                       fu_rd_we,
  input  logic [NUM_FU*PHYS_REG_IDX_W-1:0]        fu_phys_rd,
  input  logic [NUM_FU*INT_DATA_W-1:0]            fu_result,
  input  logic [NUM_FU*ROB_IDX_W-1:0]             fu_rob_idx,
  output logic                                    wb_valid,
  output logic                                    wb_rd_we,
  output logic [PHYS_REG_IDX_W-1:0]               wb_phys_rd,
  output logic [INT_DATA_W-1:0]                   wb_result,
  output logic [ROB_IDX_W-1:0]                    wb_rob_idx,
  output logic [BYPASS_LENGTH-1:0]                byp_valid,
  output logic [BYPASS_LENGTH*PHYS_REG_IDX_W-1:0] byp_phys_rd,
  output logic [BYPASS_LENGTH*INT_DATA_W-1:0]     byp_result,
  input  logic [2*PHYS_REG_IDX_W-1:0]             q_tag,
  output logic [1:0]                              q_hit,
  output logic [2*INT_DATA_W-1:0]                 q_data
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned PW    = PHYS_REG_IDX_W;
  localparam int unsigned DW    = INT_DATA_W;
  localparam int unsigned RW    = ROB_IDX_W;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             grant;
  int unsigned      scan_idx;
  logic [PW-1:0]    sel_phys_rd;
  logic [DW-1:0]    sel_result;
  logic [RW-1:0]    sel_rob_idx;
  logic             sel_rd_we;

  // Round-robin scan from rr_ptr upward with wrap; first requester wins.
  // The grant is suppressed during flush and while reset is asserted.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    fu_ready  = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
      if (!grant && fu_valid[scan_idx]) begin
        grant     = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
    if (rst || flush) grant = 1'b0;
    if (grant) fu_ready[grant_idx] = 1'b1;
  end

  // Payload of the selected FU and the pointer value after a grant.
  always_comb begin
    sel_phys_rd = fu_phys_rd[32'(grant_idx)*PW +: PW];
    sel_result  = fu_result[32'(grant_idx)*DW +: DW];
    sel_rob_idx = fu_rob_idx[32'(grant_idx)*RW +: RW];
    sel_rd_we   = fu_rd_we[grant_idx];
    next_ptr    = (32'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  // Writeback register, bypass shift history and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      wb_valid    <= 1'b0;
      wb_rd_we    <= 1'b0;
      wb_phys_rd  <= '0;
      wb_result   <= '0;
      wb_rob_idx  <= '0;
      byp_valid   <= '0;
      byp_phys_rd <= '0;
      byp_result  <= '0;
    end else if (flush) begin
      // Tags/data may go stale; only the valid bits matter after a flush.
      wb_valid  <= 1'b0;
      wb_rd_we  <= 1'b0;
      byp_valid <= '0;
    end else begin
      wb_valid <= grant;
      wb_rd_we <= grant & sel_rd_we;
      if (grant) begin
        rr_ptr     <= next_ptr;
        wb_phys_rd <= sel_phys_rd;
        wb_result  <= sel_result;
        wb_rob_idx <= sel_rob_idx;
      end
      for (int unsigned k = BYPASS_LENGTH - 1; k > 0; k--) begin
        byp_valid[k]             <= byp_valid[k-1];
        byp_phys_rd[k*PW +: PW]  <= byp_phys_rd[(k-1)*PW +: PW];
        byp_result[k*DW +: DW]   <= byp_result[(k-1)*DW +: DW];
      end
      // Non-writing results enter as an invalid bubble.
      byp_valid[0]       <= grant & sel_rd_we;
      byp_phys_rd[PW-1:0] <= sel_phys_rd;
      byp_result[DW-1:0]  <= sel_result;
    end
  end

  // Lookup: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    q_hit  = '0;
    q_data = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int k = int'(BYPASS_LENGTH) - 1; k >= 0; k--) begin
        if (byp_valid[k] && (byp_phys_rd[k*PW +: PW] == q_tag[p*PW +: PW])) begin
          q_hit[p]            = 1'b1;
          q_data[p*DW +: DW]  = byp_result[k*DW +: DW];
        end
      end
    end
  end

endmodule
